// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, SPI mode constants and sizing helper for the SPI master.
package spi_pkg;
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_TRANSFER = 3'd2,
      ST_HOLD     = 3'd3,
      ST_DONE     = 3'd4
   } spi_state_e;
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;
   function automatic int div_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period divider producing sclk and one-cycle leading/trailing edge strobes.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic idle_lvl,
   output logic sclk,
   output logic lead_edge,
   output logic trail_edge
);
   import spi_pkg::*;
   localparam int CW = div_w(CLK_DIV);
   logic [CW-1:0] cnt;
   logic tick;
   assign tick = en && cnt == CW'(CLK_DIV - 1);
   assign lead_edge = tick && sclk == idle_lvl;
   assign trail_edge = tick && sclk != idle_lvl;
   // Disabled: hold the divider cleared and park sclk at the idle level.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         sclk <= idle_lvl;
      end else begin
         cnt  <= tick ? '0 : cnt + 1'b1;
         sclk <= sclk ^ tick;
      end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master transaction FSM, MSB-first shifting, MISO capture and chip-select decode.
module spi_master_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8,
   parameter int NUM_CS  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_W-1:0]         tx_data,
   input  logic [$clog2(NUM_CS)-1:0] cs_sel,
   input  logic                      cpol,
   input  logic                      cpha,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_W-1:0]         rx_data,
   output logic                      sclk,
   output logic                      mosi,
   input  logic                      miso,
   output logic [NUM_CS-1:0]         cs_n
);
   import spi_pkg::*;
   localparam int PW  = div_w(CLK_DIV);
   localparam int EW  = $clog2(2 * DATA_W);
   localparam int CSW = $clog2(NUM_CS);
   spi_state_e state_q, state_d;
   logic [PW-1:0] ph_cnt;
   logic [EW-1:0] edge_cnt;
   logic [DATA_W-1:0] tx_sh, rx_sh;
   logic [CSW-1:0] cs_q;
   logic [1:0] miso_q;
   logic cpol_q, cpha_q, lead, trail, accept, ph_end, last_edge, sample, shift;
   assign accept    = state_q == ST_IDLE && start;
   assign ph_end    = ph_cnt == PW'(CLK_DIV - 1);
   assign last_edge = edge_cnt == EW'(2 * DATA_W - 1);
   assign sample    = cpha_q ? trail : lead;
   // CPHA=0 presents the MSB at accept, so its final trailing edge must not shift.
   assign shift     = cpha_q ? lead : trail && !last_edge;
   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk        (clk),
      .rst        (rst),
      .en         (state_q == ST_TRANSFER),
      .idle_lvl   (state_q == ST_IDLE ? cpol : cpol_q),
      .sclk       (sclk),
      .lead_edge  (lead),
      .trail_edge (trail)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= ST_IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     state_d = start ? ST_SETUP : ST_IDLE;
         ST_SETUP:    state_d = ph_end ? ST_TRANSFER : ST_SETUP;
         ST_TRANSFER: state_d = (trail && last_edge) ? ST_HOLD : ST_TRANSFER;
         ST_HOLD:     state_d = ph_end ? ST_DONE : ST_HOLD;
         default:     state_d = ST_IDLE;
      endcase
   end
   // An out-of-range cs_q matches no bit, leaving every select deasserted.
   always_comb begin
      busy = state_q != ST_IDLE;
      done = state_q == ST_DONE;
      cs_n = '1;
      for (int i = 0; i < NUM_CS; i++) cs_n[i] = !(busy && cs_q == CSW'(i));
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ph_cnt   <= '0;
         edge_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         cs_q     <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         mosi     <= 1'b0;
         miso_q   <= '0;
      end else begin
         miso_q <= {miso_q[0], miso};
         ph_cnt <= ((state_q == ST_SETUP || state_q == ST_HOLD) && !ph_end) ? ph_cnt + 1'b1 : '0;
         if (accept) begin
            tx_sh    <= tx_data;
            cs_q     <= cs_sel;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            mosi     <= tx_data[DATA_W-1];
            edge_cnt <= '0;
         end else begin
            if (lead || trail) edge_cnt <= edge_cnt + 1'b1;
            if (shift) begin
               mosi  <= cpha_q ? tx_sh[DATA_W-1] : tx_sh[DATA_W-2];
               tx_sh <= tx_sh << 1;
            end
            if (sample) rx_sh <= {rx_sh[DATA_W-2:0], miso_q[1]};
         end
         if (state_q == ST_HOLD && state_d == ST_DONE) rx_data <= rx_sh;
      end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed checks of spi_master_ctrl timing, modes, chip selects and reset abort.
module tb_spi_master_ctrl;
   import spi_pkg::*;
   logic clk = 1'b0, rst = 1'b0;
   logic start = 1'b0, start6 = 1'b0, start3 = 1'b0;
   logic [7:0] tx_data = '0;
   logic [1:0] cs_sel = '0, cs_sel3 = '0;
   logic [2:0] cs_sel6 = '0;
   logic cpol = 1'b0, cpha = 1'b0;
   logic busy, done, sclk, mosi, miso;
   logic [7:0] rx_data;
   logic [3:0] cs_n;
   logic busy6, done6, sclk6, mosi6, busy3, done3, sclk3, mosi3;
   logic [7:0] rx6, rx3;
   logic [5:0] cs_n6;
   logic [2:0] cs_n3;
   logic loop = 1'b1;
   logic s_miso = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_lead = 1'b0, s_last = 1'b0, sel_prev = 1'b1;
   logic [7:0] s_out = '0, s_in = '0;
   int s_bit = 0;
   int errors = 0, checks = 0, done_cnt = 0, rises = 0, toggles = 0, lat = 0, busy_n = 0;
   logic [3:0] cs_setup, cs_mid, cs_hold;
   wire sel_n = &cs_n;
   always #5 clk = ~clk;
   assign miso = loop ? mosi : s_miso;
   spi_master_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
      .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );
   spi_master_ctrl #(.NUM_CS(6)) u_cs6 (
      .clk(clk), .rst(rst), .start(start6), .tx_data(tx_data), .cs_sel(cs_sel6), .cpol(cpol), .cpha(cpha),
      .busy(busy6), .done(done6), .rx_data(rx6), .sclk(sclk6), .mosi(mosi6), .miso(mosi6), .cs_n(cs_n6)
   );
   spi_master_ctrl #(.NUM_CS(3)) u_cs3 (
      .clk(clk), .rst(rst), .start(start3), .tx_data(tx_data), .cs_sel(cs_sel3), .cpol(cpol), .cpha(cpha),
      .busy(busy3), .done(done3), .rx_data(rx3), .sclk(sclk3), .mosi(mosi3), .miso(mosi3), .cs_n(cs_n3)
   );
   always @(negedge clk) if (done) done_cnt++;
   always @(posedge sclk) rises++;
   always @(sclk) toggles++;
   // Behavioural slave: samples and shifts on the edges its mode dictates.
   always @(sclk or sel_n) begin
      if (!sel_n && sel_prev) begin
         s_bit = 0;
         s_in = '0;
         s_miso = s_cpha ? 1'b0 : s_out[7];
      end else if (!sel_n && sclk != s_last) begin
         s_lead = sclk != s_cpol;
         if (s_lead ^ s_cpha) s_in = {s_in[6:0], mosi};
         else if (s_cpha) begin
            s_miso = s_out[3'(7 - s_bit)];
            s_bit++;
         end else begin
            s_bit++;
            if (s_bit < 8) s_miso = s_out[3'(7 - s_bit)];
         end
      end
      sel_prev = sel_n;
      s_last = sclk;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run_xfer(input logic [7:0] tx, input logic [1:0] mode, input logic [1:0] sel, input int poke);
      @(negedge clk);
      {cpol, cpha} = mode;
      {s_cpol, s_cpha} = mode;
      cs_sel = sel;
      tx_data = tx;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0;
      lat = 0;
      busy_n = 0;
      for (int i = 1; i <= 200; i++) begin
         if (i == poke) begin
            start = 1'b1;
            tx_data = 8'hFF;
         end
         if (i == poke + 1) start = 1'b0;
         if (i == 1) cs_setup = cs_n;
         if (i == 40) cs_mid = cs_n;
         if (i == 70) cs_hold = cs_n;
         if (busy) busy_n++;
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask
   initial begin
      int d0, acc, n, idle_n;
      logic prev_busy;
      int dt[3];
      logic [7:0] rxs[3];
      #3 rst = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx", rx_data, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_cs_n", cs_n, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      // Mode 0 loopback
      loop = 1'b1;
      run_xfer(8'hA5, MODE0, 2'd0, 0);
      check("m0_latency", lat, 73);
      check("m0_busy_cycles", busy_n, 73);
      check("m0_rx", rx_data, 8'hA5);
      check("m0_rises", rises, 8);
      @(negedge clk);
      check("m0_busy_after", busy, 0);
      check("m0_cs_after", cs_n, 4'hF);
      check("m0_mosi_hold", mosi, 1);
      // Mode 3 against slave model
      loop = 1'b0;
      s_out = 8'h3C;
      run_xfer(8'hC3, MODE3, 2'd1, 0);
      check("m3_latency", lat, 73);
      check("m3_rx", rx_data, 8'h3C);
      check("m3_slave_in", s_in, 8'hC3);
      @(negedge clk);
      check("m3_sclk_idle", sclk, 1);
      // Mode 1 with ignored restart
      s_out = 8'h42;
      d0 = done_cnt;
      run_xfer(8'h81, MODE1, 2'd0, 20);
      check("m1_latency", lat, 73);
      check("m1_slave_in", s_in, 8'h81);
      check("m1_rx", rx_data, 8'h42);
      repeat (5) @(negedge clk);
      check("m1_one_done", done_cnt - d0, 1);
      check("m1_idle", busy, 0);
      // Mode 2 abort by reset after the 5th sclk edge
      loop = 1'b1;
      @(negedge clk);
      {cpol, cpha} = MODE2;
      tx_data = 8'h77;
      cs_sel = 2'd0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      toggles = 0;
      for (int i = 0; i < 100 && toggles < 5; i++) @(negedge clk);
      check("rst_mid_edges", toggles, 5);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      check("rst_mid_cs_n", cs_n, 4'hF);
      check("rst_mid_sclk", sclk, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("rst_mid_no_done", done_cnt - d0, 0);
      run_xfer(8'h5A, MODE2, 2'd0, 0);
      check("m2_latency", lat, 73);
      check("m2_rx", rx_data, 8'h5A);
      // Chip-select decode
      run_xfer(8'h3E, MODE0, 2'd2, 0);
      check("cs2_setup", cs_setup, 4'b1011);
      check("cs2_transfer", cs_mid, 4'b1011);
      check("cs2_hold", cs_hold, 4'b1011);
      check("cs2_rx", rx_data, 8'h3E);
      @(negedge clk);
      tx_data = 8'h96;
      cs_sel6 = 3'd5;
      start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         if (i == 40) check("cs6_sel5", cs_n6, 6'b011111);
         if (done6) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      check("cs6_latency", lat, 73);
      check("cs6_rx", rx6, 8'h96);
      @(negedge clk);
      tx_data = 8'h69;
      cs_sel3 = 2'd3;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         if (i == 40) check("cs3_out_of_range", cs_n3, 3'b111);
         if (done3) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      check("cs3_latency", lat, 73);
      check("cs3_rx", rx3, 8'h69);
      // Back-to-back with start held high
      @(negedge clk);
      {cpol, cpha} = MODE0;
      tx_data = 8'h11;
      @(negedge clk);
      start = 1'b1;
      acc = 0;
      n = 0;
      idle_n = 0;
      prev_busy = 1'b0;
      dt = '{0, 0, 0};
      rxs = '{8'h0, 8'h0, 8'h0};
      for (int i = 1; i <= 300 && n < 3; i++) begin
         @(negedge clk);
         if (busy && !prev_busy) acc++;
         prev_busy = busy;
         if (!busy) idle_n++;
         tx_data = (acc == 1) ? 8'h22 : 8'h33;
         if (done) begin
            dt[n] = i;
            rxs[n] = rx_data;
            n++;
         end
      end
      start = 1'b0;
      check("b2b_count", n, 3);
      check("b2b_first", dt[0], 73);
      check("b2b_gap1", dt[1] - dt[0], 74);
      check("b2b_gap2", dt[2] - dt[1], 74);
      check("b2b_idle", idle_n, 2);
      check("b2b_rx0", rxs[0], 8'h11);
      check("b2b_rx1", rxs[1], 8'h22);
      check("b2b_rx2", rxs[2], 8'h33);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
